// File: rtl/shifter_arbiter.sv
// Shares one 32-bit logical-right shifter among NUM_REQ requesters, one shift in flight.
// Build option SHARB_FIXED_PRIO_EN: lowest index always wins instead of round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; arbitrate and latch operands
// S_ISSUE | shifter driven with SRL; result captured at cycle end
// S_RESP  | result held on resp_* until resp_ready
module shifter_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_data,
    input  logic [5*NUM_REQ-1:0]   req_shamt,
    output logic [31:0]            sh_dataA,
    output logic [4:0]             sh_dataB,
    output logic [5:0]             sh_signal,
    input  logic [31:0]            sh_dataOut,
    output logic                   resp_valid,
    output logic [IDX_W-1:0]       resp_id,
    output logic [31:0]            resp_data,
    input  logic                   resp_ready,
    output logic                   busy
);

    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [31:0]          win_data;
    logic [4:0]           win_shamt;
    logic [IDX_W-1:0]     rr_start;

`ifdef SHARB_FIXED_PRIO_EN
    assign rr_start = '0;
`else
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == S_RESP && resp_ready) begin
            rr_ptr <= (resp_id == IDX_W'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
        end
    end

    assign rr_start = rr_ptr;
`endif

    // First pass covers indices at/above the start point, second pass wraps to the rest.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        win_onehot = '0;
        win_data   = '0;
        win_shamt  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j] && (j >= int'(rr_start))) begin
                found      = 1'b1;
                win        = IDX_W'(j);
                win_onehot = NUM_REQ'(1) << j;
                win_data   = req_data[32*j +: 32];
                win_shamt  = req_shamt[5*j +: 5];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j]) begin
                found      = 1'b1;
                win        = IDX_W'(j);
                win_onehot = NUM_REQ'(1) << j;
                win_data   = req_data[32*j +: 32];
                win_shamt  = req_shamt[5*j +: 5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready  <= '0;
            sh_dataA   <= '0;
            sh_dataB   <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        req_ready <= win_onehot;
                        sh_dataA  <= win_data;
                        sh_dataB  <= win_shamt;
                        resp_id   <= win;
                    end
                end
                S_ISSUE: begin
                    resp_data  <= sh_dataOut;
                    resp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sh_signal = (state == S_ISSUE) ? FUNCT_SRL : 6'b000000;
    assign busy      = (state != S_IDLE);

endmodule
